// File: rtl/rtc_calendar_pkg.sv
// ---------------------------------------------------------------------------
// rtc_calendar_pkg
// Shared definitions for the real-time calendar block:
//   - field widths for second/minute/hour/day/month/year
//   - month constants JAN..DEC and per-field maxima
//   - FSM state type and the packed time-of-day/date record
//   - days_in_month(): calendar length used both by rollover and by the
//     range check of a set request (valid for years 2000..2099)
// ---------------------------------------------------------------------------
package rtc_calendar_pkg;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 7;

    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [YEAR_W-1:0] MAX_YEAR = 7'd99;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CHECK = 1'b1
    } cal_state_t;

    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   minute;
        logic [SEC_W-1:0]   second;
    } cal_time_t;

    // 2000-01-01 00:00:00
    localparam cal_time_t RESET_TIME = '{
        year:   7'd0,
        month:  4'd1,
        day:    5'd1,
        hour:   5'd0,
        minute: 6'd0,
        second: 6'd0
    };

    // Every year divisible by 4 in 2000..2099 is a leap year (2000 included),
    // so the two low bits of the year offset are enough. Months outside
    // 1..12 return 31; callers range-check the month separately.
    function automatic logic [DAY_W-1:0] days_in_month(
        input logic [MONTH_W-1:0] month,
        input logic [YEAR_W-1:0]  year
    );
        case (month)
            APR, JUN, SEP, NOV: days_in_month = 5'd30;
            FEB:                days_in_month = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:            days_in_month = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// ---------------------------------------------------------------------------
// rtc_calendar_if
// Valid/ready set channel used by a front-end (buttons, UART) to load a new
// date and time into the calendar.
//   set_valid / set_ready : handshake, fields sampled when both are high
//   set_year..set_second  : requested date/time (year is offset from 2000)
//   set_err               : one-cycle pulse, request rejected as out of range
// Modports: master = front-end, slave = rtc_calendar.
// ---------------------------------------------------------------------------
interface rtc_calendar_if;
    import rtc_calendar_pkg::*;

    logic                set_valid;
    logic                set_ready;
    logic                set_err;
    logic [YEAR_W-1:0]   set_year;
    logic [MONTH_W-1:0]  set_month;
    logic [DAY_W-1:0]    set_day;
    logic [HOUR_W-1:0]   set_hour;
    logic [MIN_W-1:0]    set_minute;
    logic [SEC_W-1:0]    set_second;

    modport master (
        output set_valid, set_year, set_month, set_day,
               set_hour, set_minute, set_second,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_year, set_month, set_day,
               set_hour, set_minute, set_second,
        output set_ready, set_err
    );

endinterface

// File: rtl/rtc_prescaler.sv
// ---------------------------------------------------------------------------
// rtc_prescaler
// Divides the board clock down to a one-second tick.
//   clk  : system clock
//   rst  : asynchronous, active-low reset (counter to 0)
//   en   : count enable; when low the counter holds its phase
//   clr  : synchronous clear to 0, wins over en (used when a new time loads)
//   tick : combinational, high during the cycle whose edge wraps the counter
// ---------------------------------------------------------------------------
module rtc_prescaler #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Phase counter 0..CLK_HZ-1; frozen while disabled so no tick is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rtc_calendar.sv
// ---------------------------------------------------------------------------
// rtc_calendar
// Binary second/minute/hour/day/month/year timekeeper with full calendar
// rollover (leap years, 2000..2099 wrapping back to 2000) and a valid/ready
// set port for loading a new date/time.
//   clk, rst   : system clock, asynchronous active-low reset
//   run_en     : 1 = time advances, 0 = prescaler and fields frozen
//   set_port   : set channel (slave side), see rtc_calendar_if
//   tick_1hz   : one-cycle pulse on every edge where the seconds advance
//   second..year : registered time fields (year offset from 2000)
// ---------------------------------------------------------------------------
module rtc_calendar
    import rtc_calendar_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    rtc_calendar_if.slave      set_port,
    output logic               tick_1hz,
    output logic [SEC_W-1:0]   second,
    output logic [MIN_W-1:0]   minute,
    output logic [HOUR_W-1:0]  hour,
    output logic [DAY_W-1:0]   day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year
);

    cal_state_t state;
    cal_state_t state_nxt;
    cal_time_t  cur;
    cal_time_t  rolled;
    cal_time_t  shadow;
    logic       tick;
    logic       accept;
    logic       set_ok;
    logic       load;

    rtc_prescaler #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (load),
        .tick (tick)
    );

    assign accept = (state == ST_RUN) && set_port.set_valid;
    assign load   = (state == ST_CHECK) && set_ok;

    // Range check of the captured request; the day limit depends on the
    // requested month and year, not on the current ones.
    always_comb begin
        set_ok = (shadow.year   <= MAX_YEAR)
              && (shadow.month  >= JAN) && (shadow.month <= DEC)
              && (shadow.day    >= 5'd1)
              && (shadow.day    <= days_in_month(shadow.month, shadow.year))
              && (shadow.hour   <= MAX_HOUR)
              && (shadow.minute <= MAX_MIN)
              && (shadow.second <= MAX_SEC);
    end

    // Time one second ahead of cur; the whole carry chain settles in a
    // single cycle and is only committed when the prescaler ticks.
    always_comb begin
        rolled = cur;
        if (cur.second != MAX_SEC) begin
            rolled.second = cur.second + 1'b1;
        end else begin
            rolled.second = '0;
            if (cur.minute != MAX_MIN) begin
                rolled.minute = cur.minute + 1'b1;
            end else begin
                rolled.minute = '0;
                if (cur.hour != MAX_HOUR) begin
                    rolled.hour = cur.hour + 1'b1;
                end else begin
                    rolled.hour = '0;
                    if (cur.day != days_in_month(cur.month, cur.year)) begin
                        rolled.day = cur.day + 1'b1;
                    end else begin
                        rolled.day = 5'd1;
                        if (cur.month != DEC) begin
                            rolled.month = cur.month + 1'b1;
                        end else begin
                            rolled.month = JAN;
                            rolled.year  = (cur.year == MAX_YEAR) ? '0 : cur.year + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // RUN accepts a request, CHECK spends exactly one cycle validating it.
    always_comb begin
        state_nxt          = state;
        set_port.set_ready = 1'b0;
        set_port.set_err   = 1'b0;
        case (state)
            ST_RUN: begin
                set_port.set_ready = 1'b1;
                if (set_port.set_valid) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                set_port.set_err = !set_ok;
                state_nxt        = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Shadow copy of the request so the front-end may change the bus while
    // the check is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= RESET_TIME;
        end else if (accept) begin
            shadow <= '{
                year:   set_port.set_year,
                month:  set_port.set_month,
                day:    set_port.set_day,
                hour:   set_port.set_hour,
                minute: set_port.set_minute,
                second: set_port.set_second
            };
        end
    end

    // A valid load overrides a coincident tick; otherwise ticks advance the
    // fields and pulse tick_1hz on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= RESET_TIME;
            tick_1hz <= 1'b0;
        end else if (load) begin
            cur      <= shadow;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= tick;
            if (tick) begin
                cur <= rolled;
            end
        end
    end

    assign second = cur.second;
    assign minute = cur.minute;
    assign hour   = cur.hour;
    assign day    = cur.day;
    assign month  = cur.month;
    assign year   = cur.year;

endmodule

// File: tb/tb_rtc_calendar.sv
// ---------------------------------------------------------------------------
// tb_rtc_calendar
// Self-checking bench for rtc_calendar with a one-second period of 4 clocks.
// The reference keeps time as a count of seconds since 2000-01-01 and turns
// it back into calendar fields with day/month length arithmetic.
// ---------------------------------------------------------------------------
module tb_rtc_calendar;

    localparam int     CLK_HZ  = 4;
    localparam longint CENTURY = 64'd36525 * 64'd86400;

    typedef struct {
        int y;
        int mo;
        int d;
        int h;
        int mi;
        int s;
    } tm_t;

    typedef struct {
        tm_t set;
        bit  exp_err;
        tm_t exp_after;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en;
    logic       tick_1hz;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;

    int vec_count  = 0;
    int miss_count = 0;

    longint m_secs;
    int     m_phase;
    bit     m_check;
    bit     m_tick;
    tm_t    m_shadow;

    rtc_calendar_if set_if ();

    rtc_calendar #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_en   (run_en),
        .set_port (set_if.slave),
        .tick_1hz (tick_1hz),
        .second   (second),
        .minute   (minute),
        .hour     (hour),
        .day      (day),
        .month    (month),
        .year     (year)
    );

    always #5 clk = ~clk;

    // ---------------- reference calendar arithmetic ----------------
    function automatic int month_len(int m, int y);
        int lens [12];
        lens = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        if (m == 2 && (y % 4) == 0) return 29;
        return lens[m-1];
    endfunction

    function automatic int year_len(int y);
        return ((y % 4) == 0) ? 366 : 365;
    endfunction

    function automatic bit valid_tm(tm_t t);
        return (t.y >= 0) && (t.y <= 99) && (t.mo >= 1) && (t.mo <= 12)
            && (t.d >= 1) && (t.d <= month_len(t.mo, t.y))
            && (t.h >= 0) && (t.h <= 23) && (t.mi >= 0) && (t.mi <= 59)
            && (t.s >= 0) && (t.s <= 59);
    endfunction

    function automatic longint to_secs(tm_t t);
        longint days = 0;
        for (int y = 0; y < t.y; y++) days += year_len(y);
        for (int m = 1; m < t.mo; m++) days += month_len(m, t.y);
        days += t.d - 1;
        return days * 86400 + longint'(t.h) * 3600 + longint'(t.mi) * 60 + longint'(t.s);
    endfunction

    function automatic tm_t from_secs(longint s);
        tm_t    t;
        longint days = s / 86400;
        longint r    = s % 86400;
        t.h  = int'(r / 3600);
        t.mi = int'((r % 3600) / 60);
        t.s  = int'(r % 60);
        t.y  = 0;
        while (days >= year_len(t.y)) begin
            days -= year_len(t.y);
            t.y++;
        end
        t.mo = 1;
        while (days >= month_len(t.mo, t.y)) begin
            days -= month_len(t.mo, t.y);
            t.mo++;
        end
        t.d = int'(days) + 1;
        return t;
    endfunction

    function automatic tm_t mk(int y, int mo, int d, int h, int mi, int s);
        tm_t t;
        t.y = y; t.mo = mo; t.d = d; t.h = h; t.mi = mi; t.s = s;
        return t;
    endfunction

    // ---------------- reference cycle behaviour ----------------
    task automatic model_reset();
        m_secs   = 0;
        m_phase  = 0;
        m_check  = 1'b0;
        m_tick   = 1'b0;
        m_shadow = mk(0, 1, 1, 0, 0, 0);
    endtask

    task automatic model_edge();
        bit tick_now;
        tick_now = run_en && (m_phase == CLK_HZ - 1);
        if (run_en) m_phase = (m_phase == CLK_HZ - 1) ? 0 : m_phase + 1;
        if (m_check) begin
            m_check = 1'b0;
            if (valid_tm(m_shadow)) begin
                m_secs  = to_secs(m_shadow);
                m_phase = 0;
                m_tick  = 1'b0;
            end else begin
                if (tick_now) m_secs = (m_secs + 1) % CENTURY;
                m_tick = tick_now;
            end
        end else begin
            if (tick_now) m_secs = (m_secs + 1) % CENTURY;
            m_tick = tick_now;
            if (set_if.set_valid) begin
                m_shadow = mk(int'(set_if.set_year), int'(set_if.set_month),
                              int'(set_if.set_day), int'(set_if.set_hour),
                              int'(set_if.set_minute), int'(set_if.set_second));
                m_check = 1'b1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        tm_t e;
        e = from_secs(m_secs);
        checkOutput("second",   32'(second),   32'(e.s));
        checkOutput("minute",   32'(minute),   32'(e.mi));
        checkOutput("hour",     32'(hour),     32'(e.h));
        checkOutput("day",      32'(day),      32'(e.d));
        checkOutput("month",    32'(month),    32'(e.mo));
        checkOutput("year",     32'(year),     32'(e.y));
        checkOutput("tick_1hz", 32'(tick_1hz), 32'(m_tick));
    endtask

    task automatic check_comb();
        checkOutput("set_ready", 32'(set_if.set_ready), 32'(!m_check));
        checkOutput("set_err",   32'(set_if.set_err),   32'(m_check && !valid_tm(m_shadow)));
    endtask

    // Entered and left at a falling edge: drive, check handshake outputs,
    // advance one clock, check registered outputs.
    task automatic applyStimulus(bit en, bit valid, tm_t t);
        run_en            = en;
        set_if.set_valid  = valid;
        set_if.set_year   = 7'(t.y);
        set_if.set_month  = 4'(t.mo);
        set_if.set_day    = 5'(t.d);
        set_if.set_hour   = 5'(t.h);
        set_if.set_minute = 6'(t.mi);
        set_if.set_second = 6'(t.s);
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_set(tm_t t);
        applyStimulus(1'b1, 1'b1, t);
        applyStimulus(1'b1, 1'b0, t);
    endtask

    // Number of clocks until tick_1hz is seen, -1 if it never shows.
    task automatic wait_tick(output int n);
        tm_t idle;
        idle = mk(0, 0, 0, 0, 0, 0);
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, idle);
            if (tick_1hz === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_fields(string tag, tm_t e);
        checkOutput({tag, "_sec"}, 32'(second), 32'(e.s));
        checkOutput({tag, "_min"}, 32'(minute), 32'(e.mi));
        checkOutput({tag, "_hr"},  32'(hour),   32'(e.h));
        checkOutput({tag, "_day"}, 32'(day),    32'(e.d));
        checkOutput({tag, "_mon"}, 32'(month),  32'(e.mo));
        checkOutput({tag, "_yr"},  32'(year),   32'(e.y));
    endtask

    vec_t vecs [15];

    initial begin
        tm_t idle;
        tm_t pre;
        tm_t t;
        int  n;
        int  ticks;
        logic err_seen;
        logic [5:0] held_sec;

        idle = mk(0, 0, 0, 0, 0, 0);
        pre  = mk(10, 5, 5, 10, 10, 10);

        vecs[0]  = '{mk(23, 12, 31, 23, 59, 59), 1'b0, mk(24, 1, 1, 0, 0, 0)};
        vecs[1]  = '{mk(24, 2, 28, 23, 59, 59),  1'b0, mk(24, 2, 29, 0, 0, 0)};
        vecs[2]  = '{mk(23, 2, 28, 23, 59, 59),  1'b0, mk(23, 3, 1, 0, 0, 0)};
        vecs[3]  = '{mk(99, 12, 31, 23, 59, 59), 1'b0, mk(0, 1, 1, 0, 0, 0)};
        vecs[4]  = '{mk(24, 2, 29, 23, 59, 59),  1'b0, mk(24, 3, 1, 0, 0, 0)};
        vecs[5]  = '{mk(23, 4, 30, 23, 59, 59),  1'b0, mk(23, 5, 1, 0, 0, 0)};
        vecs[6]  = '{mk(0, 1, 1, 0, 0, 59),      1'b0, mk(0, 1, 1, 0, 1, 0)};
        vecs[7]  = '{mk(23, 13, 1, 0, 0, 0),     1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[8]  = '{mk(23, 2, 29, 0, 0, 0),     1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[9]  = '{mk(23, 6, 1, 24, 0, 0),     1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[10] = '{mk(23, 6, 0, 1, 0, 0),      1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[11] = '{mk(23, 6, 1, 1, 60, 0),     1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[12] = '{mk(23, 6, 1, 1, 0, 60),     1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[13] = '{mk(100, 6, 1, 1, 0, 0),     1'b1, mk(10, 5, 5, 10, 10, 11)};
        vecs[14] = '{mk(23, 4, 31, 1, 0, 0),     1'b1, mk(10, 5, 5, 10, 10, 11)};

        // ---- reset ----
        rst              = 1'b0;
        run_en           = 1'b0;
        set_if.set_valid = 1'b0;
        set_if.set_year  = '0; set_if.set_month  = '0; set_if.set_day    = '0;
        set_if.set_hour  = '0; set_if.set_minute = '0; set_if.set_second = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_regs();
        checkOutput("rst_err", 32'(set_if.set_err), 32'd0);
        rst = 1'b1;

        // ---- free run from reset: a tick every 4th clock ----
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, idle);
            if (tick_1hz === 1'b1) ticks++;
        end
        checkOutput("t1_ticks", 32'(ticks), 32'd3);
        check_fields("t1", mk(0, 1, 1, 0, 0, 3));

        // ---- table of set requests ----
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].exp_err) do_set(pre);
            applyStimulus(1'b1, 1'b1, vecs[v].set);
            set_if.set_valid = 1'b0;
            #1 err_seen = set_if.set_err;
            applyStimulus(1'b1, 1'b0, vecs[v].set);
            checkOutput($sformatf("v%0d_err", v), 32'(err_seen), 32'(vecs[v].exp_err));
            wait_tick(n);
            checkOutput($sformatf("v%0d_latency", v), 32'(n), vecs[v].exp_err ? 32'd2 : 32'd4);
            check_fields($sformatf("v%0d", v), vecs[v].exp_after);
        end

        // ---- set accepted on the prescaler wrap cycle ----
        for (int i = 0; i < 8 && m_phase != CLK_HZ - 1; i++) applyStimulus(1'b1, 1'b0, idle);
        t = mk(50, 6, 15, 12, 30, 45);
        applyStimulus(1'b1, 1'b1, t);
        checkOutput("wrap_tick", 32'(tick_1hz), 32'd1);
        set_if.set_valid = 1'b0;
        #1 checkOutput("wrap_ready", 32'(set_if.set_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, t);
        checkOutput("wrap_load_tick", 32'(tick_1hz), 32'd0);
        check_fields("wrap_load", t);
        wait_tick(n);
        checkOutput("wrap_latency", 32'(n), 32'd4);
        checkOutput("wrap_next_sec", 32'(second), 32'd46);

        // ---- freeze mid-second, then resume ----
        applyStimulus(1'b1, 1'b0, idle);
        applyStimulus(1'b1, 1'b0, idle);
        held_sec = second;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, idle);
            if (tick_1hz === 1'b1) ticks++;
        end
        checkOutput("frz_ticks", 32'(ticks), 32'd0);
        checkOutput("frz_sec", 32'(second), 32'd46);
        checkOutput("frz_held", 32'(second), 32'(held_sec));
        wait_tick(n);
        checkOutput("frz_resume", 32'(n), 32'd2);
        checkOutput("frz_next_sec", 32'(second), 32'd47);

        // ---- reset while checking a bad request ----
        applyStimulus(1'b1, 1'b1, mk(23, 13, 1, 0, 0, 0));
        set_if.set_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_chk_err", 32'(set_if.set_err), 32'd0);
        checkOutput("rst_chk_ready", 32'(set_if.set_ready), 32'd1);
        check_fields("rst_chk", mk(0, 1, 1, 0, 0, 0));
        check_regs();
        @(negedge clk);
        rst = 1'b1;

        // ---- randomized traffic against the reference ----
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit vld;
            en  = ($urandom_range(0, 9) != 0);
            vld = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1) begin
                t.y  = $urandom_range(0, 99);
                t.mo = $urandom_range(1, 12);
                t.d  = ($urandom_range(0, 1) == 1) ? month_len(t.mo, t.y)
                                                   : $urandom_range(1, month_len(t.mo, t.y));
                t.h  = ($urandom_range(0, 1) == 1) ? 23 : $urandom_range(0, 23);
                t.mi = ($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 59);
                t.s  = $urandom_range(55, 59);
            end else begin
                t.y  = $urandom_range(0, 127);
                t.mo = $urandom_range(0, 15);
                t.d  = $urandom_range(0, 31);
                t.h  = $urandom_range(0, 31);
                t.mi = $urandom_range(0, 63);
                t.s  = $urandom_range(0, 63);
            end
            applyStimulus(en, vld, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
